// File: rtl/divmod_unit_pkg.sv
// Shared types and constants for the iterative divide/modulo unit.
// Contents: FSM state encoding and the fixed latency constants
// (full operations take N + DIVMOD_LAT_FULL cycles, N = iteration count).
package divmod_unit_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Accept-to-out_valid latency: N + DIVMOD_LAT_FULL for iterated ops,
    // DIVMOD_LAT_ZERO for divide-by-zero and signed overflow shortcuts.
    localparam int unsigned DIVMOD_LAT_FULL = 3;
    localparam int unsigned DIVMOD_LAT_ZERO = 2;

endpackage

// File: rtl/divmod_step.sv
// One restoring shift-subtract division step (combinational).
// Ports:
//   rem_i / rem_o : partial remainder before / after the step
//   quo_i / quo_o : dividend-quotient shift register before / after the step
//   dvs_i         : divisor magnitude
module divmod_step #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] quo_i,
    input  logic [DATA_WIDTH-1:0] dvs_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] quo_o
);

    localparam int unsigned W = DATA_WIDTH;

    logic [W:0] shifted;
    logic [W:0] diff;

    // Bit W of the difference is the borrow: set means the divisor did not fit.
    always_comb begin
        shifted = {rem_i, quo_i[W-1]};
        diff    = shifted - {1'b0, dvs_i};
        rem_o   = diff[W] ? shifted[W-1:0] : diff[W-1:0];
        quo_o   = {quo_i[W-2:0], ~diff[W]};
    end

endmodule

// File: rtl/divmod_unit.sv
// Iterative divide/modulo unit, one quotient bit per cycle.
// Optional feature macro: DIVMOD_UNIT_SIGNED_EN (signed operation; otherwise
// op_signed is ignored and overflow never asserts).
// Ports:
//   clk, reset_n           : clock, synchronous active-low reset
//   in_valid / in_ready    : request handshake (in_ready high only in IDLE)
//   dividend, divisor      : operands
//   op_signed, op_half     : signed mode, low-half (DATA_WIDTH/2) mode
//   out_valid / out_ready  : result handshake, outputs held until accepted
//   quotient, remainder    : results
//   div_zero, overflow     : result flags, valid with out_valid
module divmod_unit
    import divmod_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned OUT_REG    = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  op_signed,
    input  logic                  op_half,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_zero,
    output logic                  overflow
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned HW = DATA_WIDTH / 2;
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

`ifdef DIVMOD_UNIT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    state_e         state_q, state_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sgn_q, sgn_d;
    logic           half_q, half_d;
    logic           neg_quo_q, neg_quo_d;
    logic           neg_rem_q, neg_rem_d;
    logic           dz_q, dz_d;
    logic           ov_q, ov_d;
    logic           pend_q, pend_d;
    logic [W-1:0]   q_res_q, q_res_d;
    logic [W-1:0]   r_res_q, r_res_d;
    logic           div_zero_q, div_zero_d;
    logic           overflow_q, overflow_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;

    logic           sgn_in;
    logic [W-1:0]   eff_dvd, eff_dvs, min_eff;
    logic           ovf_in;
    logic [W-1:0]   abs_dvd, abs_dvs;
    logic [W-1:0]   res_mask;
    logic [W-1:0]   step_rem, step_quo;

    divmod_step #(.DATA_WIDTH(W)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Operand conditioning: effective width, extension and shortcut detection.
    always_comb begin
        sgn_in   = SIGNED_EN & op_signed;
        eff_dvd  = op_half ? {{HW{sgn_in & dividend[HW-1]}}, dividend[HW-1:0]} : dividend;
        eff_dvs  = op_half ? {{HW{sgn_in & divisor[HW-1]}},  divisor[HW-1:0]}  : divisor;
        min_eff  = op_half ? {{HW{1'b1}}, 1'b1, {(HW-1){1'b0}}} : {1'b1, {(W-1){1'b0}}};
        ovf_in   = sgn_in && (eff_dvd == min_eff) && (eff_dvs == '1);
        abs_dvd  = (sgn_q && quo_q[W-1]) ? (-quo_q) : quo_q;
        abs_dvs  = (sgn_q && dvs_q[W-1]) ? (-dvs_q) : dvs_q;
        res_mask = half_q ? {{HW{1'b0}}, {HW{1'b1}}} : '1;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        sgn_d       = sgn_q;
        half_d      = half_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dz_d        = dz_q;
        ov_d        = ov_q;
        pend_d      = pend_q;
        q_res_d     = q_res_q;
        r_res_d     = r_res_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sgn_d     = sgn_in;
                    half_d    = op_half;
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
                    dz_d      = 1'b0;
                    ov_d      = 1'b0;
                    pend_d    = 1'b0;
                    if (eff_dvs == '0) begin
                        dz_d    = 1'b1;
                        quo_d   = '0;
                        rem_d   = eff_dvd;
                        pend_d  = 1'b1;
                        state_d = DONE;
                    end else if (ovf_in) begin
                        ov_d    = 1'b1;
                        quo_d   = min_eff;
                        rem_d   = '0;
                        pend_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        quo_d   = eff_dvd;
                        dvs_d   = eff_dvs;
                        rem_d   = '0;
                        state_d = PREP;
                    end
                end
            end
            PREP: begin
                neg_quo_d = sgn_q & (quo_q[W-1] ^ dvs_q[W-1]);
                neg_rem_d = sgn_q & quo_q[W-1];
                // Half mode: park the magnitude in the upper half so N/2 shifts consume it.
                quo_d     = half_q ? (abs_dvd << HW) : abs_dvd;
                dvs_d     = abs_dvs;
                rem_d     = '0;
                cnt_d     = half_q ? CW'(HW) : CW'(W);
                state_d   = CALC;
            end
            CALC: begin
                quo_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (neg_quo_q) quo_d = -quo_q;
                if (neg_rem_q) rem_d = -rem_q;
                state_d = DONE;
            end
            DONE: begin
                if (!out_valid_q) begin
                    // Shortcut results idle one cycle to keep their fixed turnaround.
                    if (pend_q) begin
                        pend_d = 1'b0;
                    end else begin
                        out_valid_d = 1'b1;
                        q_res_d     = quo_q & res_mask;
                        r_res_d     = rem_q & res_mask;
                        div_zero_d  = dz_q;
                        overflow_d  = ov_q;
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            half_q      <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
            ov_q        <= 1'b0;
            pend_q      <= 1'b0;
            q_res_q     <= '0;
            r_res_q     <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            sgn_q       <= sgn_d;
            half_q      <= half_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dz_q        <= dz_d;
            ov_q        <= ov_d;
            pend_q      <= pend_d;
            q_res_q     <= q_res_d;
            r_res_q     <= r_res_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;

    // Result data either from dedicated registers or straight from the working registers.
    if (OUT_REG != 0) begin : g_out_reg
        assign quotient  = q_res_q;
        assign remainder = r_res_q;
    end else begin : g_out_comb
        assign quotient  = quo_q & res_mask;
        assign remainder = rem_q & res_mask;
    end

endmodule
